// File: rtl/cpu_pkg.sv
// Shared definitions for the single-bus CPU: opcode values, control-unit
// state encoding and small opcode-class helpers.
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_SHR  = 5'd5;
    localparam logic [4:0] OP_SHRA = 5'd6;
    localparam logic [4:0] OP_SHL  = 5'd7;
    localparam logic [4:0] OP_ROR  = 5'd8;
    localparam logic [4:0] OP_ROL  = 5'd9;
    localparam logic [4:0] OP_AND  = 5'd10;
    localparam logic [4:0] OP_OR   = 5'd11;
    localparam logic [4:0] OP_ADDI = 5'd12;
    localparam logic [4:0] OP_ANDI = 5'd13;
    localparam logic [4:0] OP_ORI  = 5'd14;
    localparam logic [4:0] OP_MUL  = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16;
    localparam logic [4:0] OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18;
    localparam logic [4:0] OP_BR   = 5'd19;
    localparam logic [4:0] OP_JR   = 5'd20;
    localparam logic [4:0] OP_JAL  = 5'd21;
    localparam logic [4:0] OP_IN   = 5'd22;
    localparam logic [4:0] OP_OUT  = 5'd23;
    localparam logic [4:0] OP_MFHI = 5'd24;
    localparam logic [4:0] OP_MFLO = 5'd25;
    localparam logic [4:0] OP_NOP  = 5'd26;
    localparam logic [4:0] OP_HALT = 5'd27;

    localparam logic [3:0] ST_RESET = 4'd0;
    localparam logic [3:0] ST_T0    = 4'd1;
    localparam logic [3:0] ST_T1    = 4'd2;
    localparam logic [3:0] ST_T2    = 4'd3;
    localparam logic [3:0] ST_T3    = 4'd4;
    localparam logic [3:0] ST_T4    = 4'd5;
    localparam logic [3:0] ST_T5    = 4'd6;
    localparam logic [3:0] ST_T6    = 4'd7;
    localparam logic [3:0] ST_T7    = 4'd8;
    localparam logic [3:0] ST_HALT  = 4'd9;

    typedef enum logic [3:0] {
        RESET = ST_RESET,
        T0    = ST_T0,
        T1    = ST_T1,
        T2    = ST_T2,
        T3    = ST_T3,
        T4    = ST_T4,
        T5    = ST_T5,
        T6    = ST_T6,
        T7    = ST_T7,
        HALT  = ST_HALT
    } state_t;

    function automatic logic is_alu_r(input logic [4:0] op);
        return (op >= OP_ADD) && (op <= OP_OR);
    endfunction

    function automatic logic is_alu_imm(input logic [4:0] op);
        return (op >= OP_ADDI) && (op <= OP_ORI);
    endfunction

    function automatic logic is_undef(input logic [4:0] op);
        return op > OP_HALT;
    endfunction

endpackage

// File: rtl/cu_wait_counter.sv
// Memory wait-state counter: reloads to MEM_WAIT while load is high and
// counts down otherwise; done is high once the count has reached zero.
module cu_wait_counter
    import cpu_pkg::*;
#(
    parameter int MEM_WAIT = 0
)
(
    input  logic clock,
    input  logic clear,
    input  logic load,
    output logic done
);

    localparam int W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

    logic [W-1:0] count;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear)
            count <= W'(MEM_WAIT);
        else if (load)
            count <= W'(MEM_WAIT);
        else if (count != '0)
            count <= count - W'(1);
    end

    assign done = (count == '0);

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control sequencer for the 32-bit single-bus CPU.
// Define CU_ILLEGAL_TRAP_EN to trap opcodes 28-31 into HALT with a sticky illegal flag.
module control_unit
    import cpu_pkg::*;
#(
    parameter int MEM_WAIT = 0
)
(
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        stop,
    output logic        run,
    output logic        illegal,
    output logic [31:0] ops,
    output logic        PCout, IncPC, PCin, MARin, Read, Write, MDRin, MDRout, IRin,
    output logic        gra, grb, grc, rin, rout, BAout, Cout,
    output logic        RYin, RZin, RZLOout, RZHIout, HIin, LOin, HIout, LOout, CONin,
    output logic        InPortOut, OutPortIn
);

    state_t     state, next_state;
    logic [4:0] op;
    logic [4:0] ops_code;
    logic       ram_state, wait_load, wait_done;

    // Register fields are decoded by the datapath, not here.
    logic unused_ir;
    assign unused_ir = ^ir[26:0];

    assign op = ir[31:27];

`ifdef CU_ILLEGAL_TRAP_EN
    localparam state_t UNDEF_NEXT = HALT;
    logic illegal_q;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear)
            illegal_q <= 1'b0;
        else if (state == T2 && is_undef(op))
            illegal_q <= 1'b1;
    end

    assign illegal = illegal_q;
`else
    localparam state_t UNDEF_NEXT = T0;
    assign illegal = 1'b0;
`endif

    // Memory states stretch by MEM_WAIT cycles; the counter reloads outside them.
    assign ram_state = (state == T1) || (state == T6 && op == OP_LD) || (state == T7 && op == OP_ST);
    assign wait_load = !ram_state || wait_done;

    cu_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
        .clock (clock),
        .clear (clear),
        .load  (wait_load),
        .done  (wait_done)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear)
            state <= RESET;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            RESET: next_state = T0;
            T0:    next_state = stop ? HALT : T1;
            T1:    if (wait_done) next_state = T2;
            T2: begin
                if (op == OP_HALT)
                    next_state = HALT;
                else if (op == OP_NOP)
                    next_state = T0;
                else if (is_undef(op))
                    next_state = UNDEF_NEXT;
                else
                    next_state = T3;
            end
            T3: next_state = (op inside {OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO}) ? T0 : T4;
            T4: next_state = (op inside {OP_NEG, OP_NOT, OP_JAL}) ? T0 : T5;
            T5: next_state = (op inside {OP_LD, OP_ST, OP_MUL, OP_DIV, OP_BR}) ? T6 : T0;
            T6: begin
                if (op == OP_LD)
                    next_state = wait_done ? T7 : T6;
                else if (op == OP_ST)
                    next_state = T7;
                else
                    next_state = T0;
            end
            T7:      next_state = (op == OP_ST && !wait_done) ? T7 : T0;
            HALT:    next_state = HALT;
            default: next_state = RESET;
        endcase
    end

    always_comb begin
        {PCout, IncPC, PCin, MARin, Read, Write, MDRin, MDRout, IRin} = '0;
        {gra, grb, grc, rin, rout, BAout, Cout} = '0;
        {RYin, RZin, RZLOout, RZHIout, HIin, LOin, HIout, LOout, CONin} = '0;
        {InPortOut, OutPortIn} = '0;
        ops_code = 5'd0;
        run = (state != RESET) && (state != HALT);
        case (state)
            T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
            T1: begin Read = 1'b1; MDRin = 1'b1; end
            T2: begin MDRout = 1'b1; IRin = 1'b1; end
            T3: begin
                if (is_alu_r(op) || is_alu_imm(op)) begin grb = 1'b1; rout = 1'b1; RYin = 1'b1; end
                else if (op inside {OP_LDI, OP_LD, OP_ST}) begin grb = 1'b1; BAout = 1'b1; RYin = 1'b1; end
                else if (op inside {OP_MUL, OP_DIV}) begin gra = 1'b1; rout = 1'b1; RYin = 1'b1; end
                else if (op inside {OP_NEG, OP_NOT}) begin grb = 1'b1; rout = 1'b1; RZin = 1'b1; ops_code = op; end
                else if (op == OP_BR) begin gra = 1'b1; rout = 1'b1; CONin = 1'b1; end
                else if (op == OP_JR) begin gra = 1'b1; rout = 1'b1; PCin = 1'b1; end
                else if (op == OP_JAL) begin PCout = 1'b1; grb = 1'b1; rin = 1'b1; end
                else if (op == OP_IN) begin InPortOut = 1'b1; gra = 1'b1; rin = 1'b1; end
                else if (op == OP_OUT) begin gra = 1'b1; rout = 1'b1; OutPortIn = 1'b1; end
                else if (op == OP_MFHI) begin HIout = 1'b1; gra = 1'b1; rin = 1'b1; end
                else if (op == OP_MFLO) begin LOout = 1'b1; gra = 1'b1; rin = 1'b1; end
            end
            T4: begin
                if (is_alu_r(op)) begin grc = 1'b1; rout = 1'b1; RZin = 1'b1; ops_code = op; end
                else if (is_alu_imm(op)) begin Cout = 1'b1; RZin = 1'b1; ops_code = op; end
                else if (op inside {OP_LDI, OP_LD, OP_ST}) begin Cout = 1'b1; RZin = 1'b1; ops_code = OP_ADD; end
                else if (op inside {OP_MUL, OP_DIV}) begin grb = 1'b1; rout = 1'b1; RZin = 1'b1; ops_code = op; end
                else if (op inside {OP_NEG, OP_NOT}) begin RZLOout = 1'b1; gra = 1'b1; rin = 1'b1; end
                else if (op == OP_BR) begin PCout = 1'b1; RYin = 1'b1; end
                else if (op == OP_JAL) begin gra = 1'b1; rout = 1'b1; PCin = 1'b1; end
            end
            T5: begin
                if (is_alu_r(op) || is_alu_imm(op) || op == OP_LDI) begin RZLOout = 1'b1; gra = 1'b1; rin = 1'b1; end
                else if (op inside {OP_LD, OP_ST}) begin RZLOout = 1'b1; MARin = 1'b1; end
                else if (op inside {OP_MUL, OP_DIV}) begin RZLOout = 1'b1; LOin = 1'b1; end
                else if (op == OP_BR) begin Cout = 1'b1; RZin = 1'b1; ops_code = OP_ADD; end
            end
            T6: begin
                if (op == OP_LD) begin Read = 1'b1; MDRin = 1'b1; end
                else if (op == OP_ST) begin gra = 1'b1; rout = 1'b1; MDRin = 1'b1; end
                else if (op inside {OP_MUL, OP_DIV}) begin RZHIout = 1'b1; HIin = 1'b1; end
                else if (op == OP_BR) begin RZLOout = 1'b1; PCin = con_ff; end
            end
            T7: begin
                if (op == OP_LD) begin MDRout = 1'b1; gra = 1'b1; rin = 1'b1; end
                else if (op == OP_ST) Write = 1'b1;
            end
            default: ;
        endcase
    end

    assign ops = {27'b0, ops_code};

endmodule
